// File: rtl/gpio_bus_arbiter_if.sv
// Bundle of the two requester channels and the GpioPort bus seen by the arbiter.
// master = the arbiter itself; slave = requesters plus the port model.
interface gpio_bus_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic              req_a;
    logic              wr_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              ack_a;
    logic [DATA_W-1:0] rdata_a;

    logic              req_b;
    logic              wr_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              ack_b;
    logic [DATA_W-1:0] rdata_b;

    logic              bus_en;
    logic              bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              busy;

    modport master (
        input  req_a, wr_a, addr_a, wdata_a,
        output ack_a, rdata_a,
        input  req_b, wr_b, addr_b, wdata_b,
        output ack_b, rdata_b,
        output bus_en, bus_wr, bus_addr, bus_wdata,
        input  bus_rdata,
        output busy
    );

    modport slave (
        output req_a, wr_a, addr_a, wdata_a,
        input  ack_a, rdata_a,
        output req_b, wr_b, addr_b, wdata_b,
        input  ack_b, rdata_b,
        input  bus_en, bus_wr, bus_addr, bus_wdata,
        output bus_rdata,
        input  busy
    );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Two-requester arbiter for the GpioPort register bus: one transaction at a time,
// round-robin or A-priority, every bus-side and requester-side output registered.
module gpio_bus_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 2,
    parameter bit FIXED_A = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    gpio_bus_arbiter_if.master  bus
);
    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            stateReg;
    logic              grantReg;      // 0 = A, 1 = B
    logic              lastBReg;      // most recent grant went to B
    logic              busEnReg;
    logic              busWrReg;
    logic [ADDR_W-1:0] busAddrReg;
    logic [DATA_W-1:0] busWdataReg;
    logic              busyReg;
    logic [N_REQ-1:0]  ackReg;
    logic [DATA_W-1:0] rdataReg [N_REQ];

    logic [N_REQ-1:0]  reqVec;
    logic [N_REQ-1:0]  wrVec;
    logic [ADDR_W-1:0] addrVec  [N_REQ];
    logic [DATA_W-1:0] wdataVec [N_REQ];

    logic              idlePick;
    logic              respOther;
    logic              respHasOther;

    assign reqVec      = {bus.req_b, bus.req_a};
    assign wrVec       = {bus.wr_b,  bus.wr_a};
    assign addrVec[0]  = bus.addr_a;
    assign addrVec[1]  = bus.addr_b;
    assign wdataVec[0] = bus.wdata_a;
    assign wdataVec[1] = bus.wdata_b;

    // Tie goes to the requester not granted last, unless A is pinned as winner.
    always_comb begin
        idlePick = 1'b0;
        if (reqVec[0] && reqVec[1]) begin
            idlePick = FIXED_A ? 1'b0 : ~lastBReg;
        end else begin
            idlePick = reqVec[1];
        end
    end

    // From RESP only the other requester may be granted; the acked one re-enters via IDLE.
    assign respOther    = ~grantReg;
    assign respHasOther = reqVec[respOther];

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= IDLE;
            grantReg    <= 1'b0;
            lastBReg    <= 1'b1;
            busEnReg    <= 1'b0;
            busWrReg    <= 1'b0;
            busAddrReg  <= '0;
            busWdataReg <= '0;
            busyReg     <= 1'b0;
            ackReg      <= '0;
        end else begin
            ackReg <= '0;
            case (stateReg)
                IDLE: begin
                    if (|reqVec) begin
                        grantReg    <= idlePick;
                        lastBReg    <= idlePick;
                        busWrReg    <= wrVec[idlePick];
                        busAddrReg  <= addrVec[idlePick];
                        busWdataReg <= wdataVec[idlePick];
                        busEnReg    <= 1'b1;
                        busyReg     <= 1'b1;
                        stateReg    <= ACCESS;
                    end
                end
                ACCESS: begin
                    busEnReg         <= 1'b0;
                    ackReg[grantReg] <= 1'b1;
                    stateReg         <= RESP;
                end
                RESP: begin
                    if (respHasOther) begin
                        grantReg    <= respOther;
                        lastBReg    <= respOther;
                        busWrReg    <= wrVec[respOther];
                        busAddrReg  <= addrVec[respOther];
                        busWdataReg <= wdataVec[respOther];
                        busEnReg    <= 1'b1;
                        stateReg    <= ACCESS;
                    end else begin
                        busyReg  <= 1'b0;
                        stateReg <= IDLE;
                    end
                end
                default: begin
                    busEnReg <= 1'b0;
                    busyReg  <= 1'b0;
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    // Read data is captured at the edge that closes ACCESS, only into the granted channel.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : gen_rdata
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdataReg[gi] <= '0;
                end else if (stateReg == ACCESS && grantReg == 1'(gi) && !busWrReg) begin
                    rdataReg[gi] <= bus.bus_rdata;
                end
            end
        end
    endgenerate

    assign bus.ack_a     = ackReg[0];
    assign bus.ack_b     = ackReg[1];
    assign bus.rdata_a   = rdataReg[0];
    assign bus.rdata_b   = rdataReg[1];
    assign bus.bus_en    = busEnReg;
    assign bus.bus_wr    = busWrReg;
    assign bus.bus_addr  = busAddrReg;
    assign bus.bus_wdata = busWdataReg;
    assign bus.busy      = busyReg;
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed and random checks of gpio_bus_arbiter in round-robin (dut0) and A-priority (dut1) builds.
module tb_gpio_bus_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    gpio_bus_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if0 ();
    gpio_bus_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if1 ();

    gpio_bus_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIXED_A(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    gpio_bus_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIXED_A(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    logic [54:0] out0;
    logic [54:0] out1;
    assign out0 = {if0.bus_en, if0.bus_wr, if0.bus_addr, if0.bus_wdata, if0.ack_a, if0.ack_b,
                   if0.rdata_a, if0.rdata_b, if0.busy};
    assign out1 = {if1.bus_en, if1.bus_wr, if1.bus_addr, if1.bus_wdata, if1.ack_a, if1.ack_b,
                   if1.rdata_a, if1.rdata_b, if1.busy};

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++;
        if (out0 !== '0) begin nFails++; $display("FAIL reset_dut0 got=%h exp=0", out0); end
        nChecks++;
        if (out1 !== '0) begin nFails++; $display("FAIL reset_dut1 got=%h exp=0", out1); end
        rst = 1'b0;
        $display("reset: outputs after reset checked");
    endtask

    task automatic test_write_a;
        if0.req_a = 1'b1; if0.wr_a = 1'b1; if0.addr_a = 2'b01; if0.wdata_a = 16'h00FF;
        @(negedge clk);
        nChecks++;
        if ({if0.bus_en, if0.bus_wr, if0.bus_addr, if0.bus_wdata, if0.ack_a, if0.busy} !==
            {1'b1, 1'b1, 2'b01, 16'h00FF, 1'b0, 1'b1}) begin
            nFails++;
            $display("FAIL write_a_access got en=%b wr=%b addr=%b wdata=%h ack=%b busy=%b exp 1 1 01 00ff 0 1",
                     if0.bus_en, if0.bus_wr, if0.bus_addr, if0.bus_wdata, if0.ack_a, if0.busy);
        end
        @(negedge clk);
        nChecks++;
        if ({if0.ack_a, if0.ack_b, if0.bus_en, if0.busy} !== 4'b1001) begin
            nFails++;
            $display("FAIL write_a_ack got ack_a=%b ack_b=%b en=%b busy=%b exp 1 0 0 1",
                     if0.ack_a, if0.ack_b, if0.bus_en, if0.busy);
        end
        if0.req_a = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({if0.busy, if0.ack_a, if0.bus_en} !== 3'b000) begin
            nFails++;
            $display("FAIL write_a_idle got busy=%b ack_a=%b en=%b exp 0 0 0", if0.busy, if0.ack_a, if0.bus_en);
        end
        $display("write_a: A wrote 00ff to addr 1");
    endtask

    task automatic test_read_a;
        if0.req_a = 1'b1; if0.wr_a = 1'b0; if0.addr_a = 2'b10; if0.wdata_a = 16'h0000;
        @(negedge clk);
        nChecks++;
        if ({if0.bus_en, if0.bus_wr, if0.bus_addr} !== 4'b1010) begin
            nFails++;
            $display("FAIL read_a_access got en=%b wr=%b addr=%b exp 1 0 10", if0.bus_en, if0.bus_wr, if0.bus_addr);
        end
        if0.bus_rdata = 16'hA5A5;
        @(negedge clk);
        if0.bus_rdata = 16'h0000;
        nChecks++;
        if ({if0.ack_a, if0.rdata_a, if0.rdata_b} !== {1'b1, 16'hA5A5, 16'h0000}) begin
            nFails++;
            $display("FAIL read_a_data got ack_a=%b rdata_a=%h rdata_b=%h exp 1 a5a5 0000",
                     if0.ack_a, if0.rdata_a, if0.rdata_b);
        end
        if0.req_a = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({if0.bus_en, if0.bus_wr, if0.bus_addr, if0.rdata_a} !== {1'b0, 1'b0, 2'b10, 16'hA5A5}) begin
            nFails++;
            $display("FAIL read_a_hold got en=%b wr=%b addr=%b rdata_a=%h exp 0 0 10 a5a5",
                     if0.bus_en, if0.bus_wr, if0.bus_addr, if0.rdata_a);
        end
        $display("read_a: A read a5a5 from addr 2");
    endtask

    // Both requesters held from reset: expect A,B,A,B with bus_en on odd cycles.
    task automatic test_round_robin;
        do_reset();
        if0.req_a = 1'b1; if0.wr_a = 1'b1; if0.addr_a = 2'b01; if0.wdata_a = 16'hAAAA;
        if0.req_b = 1'b1; if0.wr_b = 1'b1; if0.addr_b = 2'b00; if0.wdata_b = 16'hBBBB;
        for (int k = 1; k <= 8; k++) begin
            logic        expA;
            logic        expEn;
            logic        expAckA;
            logic        expAckB;
            expA    = (k == 1 || k == 2 || k == 5 || k == 6);
            expEn   = (k % 2 == 1);
            expAckA = !expEn && expA;
            expAckB = !expEn && !expA;
            @(negedge clk);
            nChecks++;
            if ({if0.bus_en, if0.ack_a, if0.ack_b} !== {expEn, expAckA, expAckB} ||
                (expEn && if0.bus_wdata !== (expA ? 16'hAAAA : 16'hBBBB))) begin
                nFails++;
                $display("FAIL rr_cycle%0d got en=%b ack_a=%b ack_b=%b wdata=%h exp %b %b %b %h",
                         k, if0.bus_en, if0.ack_a, if0.ack_b, if0.bus_wdata, expEn, expAckA, expAckB,
                         expA ? 16'hAAAA : 16'hBBBB);
            end
        end
        if0.req_a = 1'b0; if0.req_b = 1'b0;
        @(negedge clk);
        nChecks++;
        if (if0.busy !== 1'b0) begin nFails++; $display("FAIL rr_idle got busy=%b exp 0", if0.busy); end
        $display("round_robin: order A,B,A,B checked");
    endtask

    task automatic test_fixed_priority;
        do_reset();
        if1.req_a = 1'b1; if1.wr_a = 1'b1; if1.addr_a = 2'b01; if1.wdata_a = 16'hAAAA;
        if1.req_b = 1'b1; if1.wr_b = 1'b1; if1.addr_b = 2'b00; if1.wdata_b = 16'hBBBB;
        for (int k = 1; k <= 8; k++) begin
            logic expA;
            logic expEn;
            expA  = (k == 1 || k == 2 || k == 5 || k == 6);
            expEn = (k % 2 == 1);
            @(negedge clk);
            nChecks++;
            if ({if1.bus_en, if1.ack_a, if1.ack_b} !== {expEn, !expEn && expA, !expEn && !expA} ||
                (expEn && if1.bus_wdata !== (expA ? 16'hAAAA : 16'hBBBB))) begin
                nFails++;
                $display("FAIL fixed_cycle%0d got en=%b ack_a=%b ack_b=%b wdata=%h exp en=%b a_turn=%b",
                         k, if1.bus_en, if1.ack_a, if1.ack_b, if1.bus_wdata, expEn, expA);
            end
        end
        if1.req_a = 1'b0; if1.req_b = 1'b0;
        @(negedge clk);
        $display("fixed_priority: order A,B,A,B checked");
    endtask

    // After a lone A grant, a simultaneous A/B request goes to B in round-robin, to A when fixed.
    task automatic test_tie_after_a;
        do_reset();
        if0.req_a = 1'b1; if0.wr_a = 1'b1; if0.addr_a = 2'b01; if0.wdata_a = 16'h1111;
        if1.req_a = 1'b1; if1.wr_a = 1'b1; if1.addr_a = 2'b01; if1.wdata_a = 16'h1111;
        if0.wr_b = 1'b1; if0.addr_b = 2'b00; if0.wdata_b = 16'h2222;
        if1.wr_b = 1'b1; if1.addr_b = 2'b00; if1.wdata_b = 16'h2222;
        repeat (2) @(negedge clk);
        if0.req_a = 1'b0; if1.req_a = 1'b0;
        @(negedge clk);
        if0.req_a = 1'b1; if0.req_b = 1'b1;
        if1.req_a = 1'b1; if1.req_b = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({if0.bus_en, if0.bus_wdata} !== {1'b1, 16'h2222}) begin
            nFails++;
            $display("FAIL tie_rr_winner got en=%b wdata=%h exp 1 2222", if0.bus_en, if0.bus_wdata);
        end
        nChecks++;
        if ({if1.bus_en, if1.bus_wdata} !== {1'b1, 16'h1111}) begin
            nFails++;
            $display("FAIL tie_fixed_winner got en=%b wdata=%h exp 1 1111", if1.bus_en, if1.bus_wdata);
        end
        @(negedge clk);
        nChecks++;
        if ({if0.ack_a, if0.ack_b, if1.ack_a, if1.ack_b} !== 4'b0110) begin
            nFails++;
            $display("FAIL tie_acks got dut0 a=%b b=%b dut1 a=%b b=%b exp 0 1 1 0",
                     if0.ack_a, if0.ack_b, if1.ack_a, if1.ack_b);
        end
        if0.req_b = 1'b0; if1.req_a = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({if0.bus_en, if0.bus_wdata, if1.bus_en, if1.bus_wdata} !== {1'b1, 16'h1111, 1'b1, 16'h2222}) begin
            nFails++;
            $display("FAIL tie_second got dut0 en=%b wdata=%h dut1 en=%b wdata=%h exp 1 1111 1 2222",
                     if0.bus_en, if0.bus_wdata, if1.bus_en, if1.bus_wdata);
        end
        @(negedge clk);
        if0.req_a = 1'b0; if1.req_b = 1'b0;
        @(negedge clk);
        $display("tie_after_a: round-robin picked B, fixed picked A");
    endtask

    task automatic test_reset_in_access;
        if0.req_b = 1'b1; if0.wr_b = 1'b1; if0.addr_b = 2'b01; if0.wdata_b = 16'h1234;
        @(negedge clk);
        nChecks++;
        if ({if0.bus_en, if0.bus_wdata} !== {1'b1, 16'h1234}) begin
            nFails++;
            $display("FAIL rst_access_pre got en=%b wdata=%h exp 1 1234", if0.bus_en, if0.bus_wdata);
        end
        rst = 1'b1;
        @(negedge clk);
        nChecks++;
        if (out0 !== '0) begin nFails++; $display("FAIL rst_in_access got=%h exp=0", out0); end
        rst = 1'b0; if0.req_b = 1'b0;
        if0.req_a = 1'b1; if0.wr_a = 1'b0; if0.addr_a = 2'b00;
        @(negedge clk);
        nChecks++;
        if (if0.bus_en !== 1'b1) begin nFails++; $display("FAIL rst_then_a_en got=%b exp=1", if0.bus_en); end
        if0.bus_rdata = 16'h5A5A;
        @(negedge clk);
        nChecks++;
        if ({if0.ack_a, if0.ack_b, if0.rdata_a} !== {1'b1, 1'b0, 16'h5A5A}) begin
            nFails++;
            $display("FAIL rst_then_a_ack got ack_a=%b ack_b=%b rdata_a=%h exp 1 0 5a5a",
                     if0.ack_a, if0.ack_b, if0.rdata_a);
        end
        if0.req_a = 1'b0;
        @(negedge clk);
        $display("reset_in_access: B write aborted, A read completed");
    endtask

    // Random traffic against a 4-register port model on dut0.
    task automatic test_random;
        logic [DATA_W-1:0] portMem [4];
        logic [DATA_W-1:0] expRd [2];
        logic              rq [2];
        logic              rqWr [2];
        logic [ADDR_W-1:0] rqAddr [2];
        logic [DATA_W-1:0] rqWdata [2];
        int                age [2];
        int                waitCnt [2];
        logic              accWr;
        logic [ADDR_W-1:0] accAddr;
        logic [DATA_W-1:0] accWdata;
        logic [DATA_W-1:0] accRead;
        logic              prevEn;
        logic [1:0]        ackV;
        int                nAcks;
        bit                stuck;
        for (int i = 0; i < 4; i++) portMem[i] = '0;
        for (int i = 0; i < 2; i++) begin
            expRd[i] = '0; rq[i] = 1'b0; rqWr[i] = 1'b0; rqAddr[i] = '0; rqWdata[i] = '0;
            age[i] = 0; waitCnt[i] = 0;
        end
        accWr = 1'b0; accAddr = '0; accWdata = '0; accRead = '0; prevEn = 1'b0; nAcks = 0; stuck = 1'b0;
        if0.req_a = 1'b0; if0.req_b = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 3000 && !stuck; cyc++) begin
            @(negedge clk);
            ackV = {if0.ack_b, if0.ack_a};
            if (ackV != 2'b00 || if0.bus_en) begin
                nChecks++;
                if (ackV == 2'b11 || (prevEn && if0.bus_en)) begin
                    nFails++;
                    $display("FAIL rand_pulse cyc=%0d got acks=%b en=%b prev_en=%b exp one-hot ack, single en",
                             cyc, ackV, if0.bus_en, prevEn);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (ackV[i]) begin
                    nAcks++;
                    nChecks++;
                    if (!prevEn || !rq[i] || accWr !== rqWr[i] || accAddr !== rqAddr[i] ||
                        accWdata !== rqWdata[i]) begin
                        nFails++;
                        $display("FAIL rand_route cyc=%0d req=%0d got wr=%b addr=%b wdata=%h exp %b %b %h",
                                 cyc, i, accWr, accAddr, accWdata, rqWr[i], rqAddr[i], rqWdata[i]);
                    end
                    if (!rqWr[i]) expRd[i] = accRead;
                    nChecks++;
                    if (if0.rdata_a !== expRd[0] || if0.rdata_b !== expRd[1]) begin
                        nFails++;
                        $display("FAIL rand_rdata cyc=%0d got a=%h b=%h exp a=%h b=%h",
                                 cyc, if0.rdata_a, if0.rdata_b, expRd[0], expRd[1]);
                    end
                    if (rq[1-i]) begin
                        waitCnt[1-i]++;
                        nChecks++;
                        if (waitCnt[1-i] > 2) begin
                            nFails++;
                            $display("FAIL rand_starve cyc=%0d req=%0d got waited=%0d grants exp <=2",
                                     cyc, 1-i, waitCnt[1-i]);
                        end
                    end
                    rq[i] = 1'b0; age[i] = 0; waitCnt[i] = 0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (rq[i]) begin
                    age[i]++;
                    if (age[i] > 20) begin
                        nChecks++; nFails++; stuck = 1'b1;
                        $display("FAIL rand_timeout cyc=%0d req=%0d got no ack after %0d cycles exp <=20",
                                 cyc, i, age[i]);
                    end
                end
            end
            if (if0.bus_en) begin
                accWr = if0.bus_wr; accAddr = if0.bus_addr; accWdata = if0.bus_wdata;
                accRead = portMem[if0.bus_addr];
                if0.bus_rdata = accRead;
                if (if0.bus_wr) portMem[if0.bus_addr] = if0.bus_wdata;
            end else begin
                if0.bus_rdata = DATA_W'($urandom);
            end
            prevEn = if0.bus_en;
            for (int i = 0; i < 2; i++) begin
                if (!rq[i] && $urandom_range(0, 2) != 0) begin
                    rq[i] = 1'b1;
                    rqWr[i] = 1'($urandom_range(0, 1));
                    rqAddr[i] = ADDR_W'($urandom_range(0, 3));
                    rqWdata[i] = DATA_W'($urandom);
                end
            end
            if0.req_a = rq[0]; if0.wr_a = rqWr[0]; if0.addr_a = rqAddr[0]; if0.wdata_a = rqWdata[0];
            if0.req_b = rq[1]; if0.wr_b = rqWr[1]; if0.addr_b = rqAddr[1]; if0.wdata_b = rqWdata[1];
        end
        if0.req_a = 1'b0; if0.req_b = 1'b0;
        nChecks++;
        if (nAcks < 500) begin nFails++; $display("FAIL rand_throughput got acks=%0d exp >=500", nAcks); end
        repeat (3) @(negedge clk);
        $display("random: %0d transactions completed", nAcks);
    endtask

    initial begin
        if0.req_a = 1'b0; if0.wr_a = 1'b0; if0.addr_a = '0; if0.wdata_a = '0;
        if0.req_b = 1'b0; if0.wr_b = 1'b0; if0.addr_b = '0; if0.wdata_b = '0; if0.bus_rdata = '0;
        if1.req_a = 1'b0; if1.wr_a = 1'b0; if1.addr_a = '0; if1.wdata_a = '0;
        if1.req_b = 1'b0; if1.wr_b = 1'b0; if1.addr_b = '0; if1.wdata_b = '0; if1.bus_rdata = '0;
        test_reset();
        test_write_a();
        test_read_a();
        test_round_robin();
        test_fixed_priority();
        test_tie_after_a();
        test_reset_in_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got simulation still running exp finished");
        $fatal(1, "watchdog expired");
    end
endmodule
